// File: rtl/inst_fetch_pkg.sv
// Shared widths, fetch state encoding and the start/branch address tables
// used by the fetch stage and its branch-target lookup.
package fetch_pkg;
  localparam int AW     = 10;
  localparam int LUT_IW = 5;
  localparam int OFF_W  = 6;
  localparam int CW     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam logic [AW-1:0] START_ADDR [4] = '{10'd0, 10'd256, 10'd512, 10'd768};

  // Regenerated by the assembler flow; entries are absolute ROM addresses.
  localparam logic [AW-1:0] BRANCH_TARGETS [32] = '{
    10'd0,   10'd37,  10'd64,  10'd600, 10'd128, 10'd160, 10'd192, 10'd1020,
    10'd256, 10'd288, 10'd320, 10'd352, 10'd384, 10'd416, 10'd448, 10'd480,
    10'd512, 10'd544, 10'd576, 10'd608, 10'd640, 10'd672, 10'd704, 10'd736,
    10'd768, 10'd800, 10'd832, 10'd864, 10'd896, 10'd928, 10'd960, 10'd1023
  };
endpackage

// File: rtl/inst_fetch_if.sv
// Control/status bundle between the decoder/ALU side and the fetch stage.
// CW sizes the cycle counter so short-counter builds share the same interface.
interface inst_fetch_if #(parameter int CW = fetch_pkg::CW);
  import fetch_pkg::*;

  logic                    Start;
  logic [1:0]              ProgSel;
  logic                    Halt;
  logic                    Stall;
  logic                    BranchAbs;
  logic [LUT_IW-1:0]       TargetIdx;
  logic                    BranchRel;
  logic signed [OFF_W-1:0] Offset;
  logic [AW-1:0]           InstAddress;
  logic                    Running;
  logic                    Done;
  logic [CW-1:0]           CycleCount;

  modport master (
    output Start, ProgSel, Halt, Stall, BranchAbs, TargetIdx, BranchRel, Offset,
    input  InstAddress, Running, Done, CycleCount
  );

  modport slave (
    input  Start, ProgSel, Halt, Stall, BranchAbs, TargetIdx, BranchRel, Offset,
    output InstAddress, Running, Done, CycleCount
  );
endinterface

// File: rtl/inst_fetch_branch_lut.sv
// Combinational branch-target lookup: 5-bit index to 10-bit absolute address.
module branch_lut
  import fetch_pkg::*;
(
  input  logic [LUT_IW-1:0] idx_i,
  output logic [AW-1:0]     target_o
);
  assign target_o = BRANCH_TARGETS[idx_i];
endmodule

// File: rtl/inst_fetch.sv
// Program counter and run sequencer feeding the instruction ROM, with a
// saturating per-run cycle counter.
module inst_fetch #(
  parameter int CW = fetch_pkg::CW
) (
  input  logic         Clk,
  input  logic         Reset,
  inst_fetch_if.slave  bus
);
  import fetch_pkg::*;

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          running_q, done_q;
  logic [AW-1:0] lut_target;
  logic [AW-1:0] rel_offset;

  branch_lut u_branch_lut (
    .idx_i    (bus.TargetIdx),
    .target_o (lut_target)
  );

  assign rel_offset = {{(AW-OFF_W){bus.Offset[OFF_W-1]}}, bus.Offset};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = START_ADDR[bus.ProgSel];
          cnt_d   = '0;
        end
      end
      RUN: begin
        // The Halt cycle and stalled cycles still count as RUN time.
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (bus.Halt)           state_d = DONE;
        else if (bus.Stall)     pc_d = pc_q;
        else if (bus.BranchAbs) pc_d = lut_target;
        else if (bus.BranchRel) pc_d = pc_q + rel_offset;
        else                    pc_d = pc_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.InstAddress = pc_q;
  assign bus.Running     = running_q;
  assign bus.Done        = done_q;
  assign bus.CycleCount  = cnt_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: vector table through a scoreboard queue, plus
// hand-written async-reset and counter-saturation sequences.
module tb_inst_fetch;
  import fetch_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  inst_fetch_if #(.CW(16)) bus ();
  inst_fetch_if #(.CW(4))  bus4 ();

  inst_fetch #(.CW(16)) dut  (.Clk(Clk), .Reset(Reset), .bus(bus));
  inst_fetch #(.CW(4))  dut4 (.Clk(Clk), .Reset(Reset), .bus(bus4));

  typedef struct {
    logic        start;
    logic [1:0]  ps;
    logic        halt;
    logic        stall;
    logic        babs;
    logic [4:0]  idx;
    logic        brel;
    logic [5:0]  off;
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          tag;
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(bit st, int ps, bit h, bit s, bit ba, int idx, bit br, int off,
                              int pc, bit r, bit d, int cnt);
    vec_t v;
    v.start = st;  v.ps = ps[1:0]; v.halt = h; v.stall = s; v.babs = ba;
    v.idx = idx[4:0]; v.brel = br; v.off = off[5:0];
    v.pc = pc[9:0]; v.run = r; v.done = d; v.cnt = cnt[15:0];
    return v;
  endfunction

  task automatic chk(string nm, int tag, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, tag, act, exp);
    end
  endtask

  task automatic drive(vec_t v, int tag, bit use4);
    exp_t e;
    if (use4) begin
      bus4.Start = v.start; bus4.ProgSel = v.ps; bus4.Halt = v.halt; bus4.Stall = v.stall;
      bus4.BranchAbs = v.babs; bus4.TargetIdx = v.idx; bus4.BranchRel = v.brel; bus4.Offset = v.off;
    end else begin
      bus.Start = v.start; bus.ProgSel = v.ps; bus.Halt = v.halt; bus.Stall = v.stall;
      bus.BranchAbs = v.babs; bus.TargetIdx = v.idx; bus.BranchRel = v.brel; bus.Offset = v.off;
    end
    e.tag = tag; e.pc = v.pc; e.run = v.run; e.done = v.done; e.cnt = v.cnt;
    sb.push_back(e);
  endtask

  task automatic sample(bit use4);
    exp_t e;
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", -1, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      if (use4) begin
        chk("addr4", e.tag, 32'(bus4.InstAddress), 32'(e.pc));
        chk("running4", e.tag, 32'(bus4.Running), 32'(e.run));
        chk("done4", e.tag, 32'(bus4.Done), 32'(e.done));
        chk("count4", e.tag, 32'(bus4.CycleCount), 32'(e.cnt));
      end else begin
        chk("addr", e.tag, 32'(bus.InstAddress), 32'(e.pc));
        chk("running", e.tag, 32'(bus.Running), 32'(e.run));
        chk("done", e.tag, 32'(bus.Done), 32'(e.done));
        chk("count", e.tag, 32'(bus.CycleCount), 32'(e.cnt));
      end
    end
  endtask

  task automatic step(vec_t v, int tag, bit use4);
    drive(v, tag, use4);
    sample(use4);
    @(negedge Clk);
  endtask

  initial begin
    vec_t idle_v;
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    drive(idle_v, 0, 0); void'(sb.pop_back());
    drive(idle_v, 0, 1); void'(sb.pop_back());

    //        st ps h  s  ba idx br off    pc  r  d  cnt
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,    0,   0, 0, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,    256, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,    257, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,    258, 1, 0, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,    259, 1, 0, 3));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,    260, 1, 0, 4));
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,    260, 0, 1, 5));
    vt.push_back(mk(0, 0, 0, 1, 1, 3, 1, 4,    260, 0, 1, 5));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,    256, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 31,   287, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 13,   300, 1, 0, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, -4,   296, 1, 0, 3));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 31,   327, 1, 0, 4));
    vt.push_back(mk(0, 0, 0, 0, 1, 7, 0, 0,    1020, 1, 0, 5));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5,    1,   1, 0, 6));
    vt.push_back(mk(0, 0, 0, 0, 1, 3, 1, 2,    600, 1, 0, 7));
    vt.push_back(mk(0, 0, 0, 1, 1, 7, 0, 0,    600, 1, 0, 8));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,    600, 1, 0, 9));
    vt.push_back(mk(0, 0, 0, 0, 1, 31, 0, 0,   1023, 1, 0, 10));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,    0,   1, 0, 11));
    vt.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0,    1,   1, 0, 12));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, -32,  993, 1, 0, 13));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,    993, 0, 1, 14));
    vt.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0,    512, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,    513, 1, 0, 1));
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,    513, 0, 1, 2));

    #12;
    chk("reset_addr", 0, 32'(bus.InstAddress), 32'd0);
    chk("reset_running", 0, 32'(bus.Running), 32'd0);
    chk("reset_done", 0, 32'(bus.Done), 32'd0);
    chk("reset_count", 0, 32'(bus.CycleCount), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) step(vt[i], i, 0);

    // Abort a run at PC=37 with an asynchronous reset between clock edges.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0), 100, 0);
    drive(mk(0, 0, 0, 0, 1, 1, 0, 0, 37, 1, 0, 1), 101, 0);
    sample(0);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_addr", 102, 32'(bus.InstAddress), 32'd0);
    chk("async_rst_running", 102, 32'(bus.Running), 32'd0);
    chk("async_rst_done", 102, 32'(bus.Done), 32'd0);
    chk("async_rst_count", 102, 32'(bus.CycleCount), 32'd0);
    @(negedge Clk);
    bus.Start = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_holds_start", 103, 32'(bus.Running), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    step(idle_v, 104, 0);

    // Narrow counter saturates instead of wrapping.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 200, 1);
    for (int k = 1; k <= 20; k++)
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, k, 1, 0, (k > 15) ? 15 : k), 200 + k, 1);
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 20, 0, 1, 15), 221, 1);

    chk("scoreboard_drained", 300, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Program-counter and fetch-control stage directly upstream of the instruction ROM.
- Drives the 10-bit instruction address and sequences a run with a Start/Done handshake.
- Applies halt, stall, absolute-branch and relative-branch requests from the decoder/ALU.
- Absolute targets come from a small branch-target LUT, since 9-bit instructions cannot hold a full 10-bit target. Also keeps a per-run cycle counter for benchmarking.

Parameters:
- AW, 10, instruction address width (1024-entry ROM).
- LUT_IW, 5, branch-target LUT index width (32 targets).
- OFF_W, 6, signed relative-branch offset width.
- CW, 16, cycle-counter width.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin a run; sampled only in IDLE or DONE.
- ProgSel  in  2  selects start address from the package constant table.
- Halt  in  1  decoder saw the halt instruction.
- Stall  in  1  hold the PC this cycle.
- BranchAbs  in  1  take an absolute branch via the LUT.
- TargetIdx  in  LUT_IW  LUT index for an absolute branch.
- BranchRel  in  1  take a relative branch.
- Offset  in  OFF_W  signed two's-complement offset for a relative branch.
- InstAddress  out  AW  current PC, fed to the ROM.
- Running  out  1  high in RUN.
- Done  out  1  high in DONE.
- CycleCount  out  CW  cycles spent in RUN in the current or last run.

Behaviour:
- Reset (async, active-high): state=IDLE, PC=0, CycleCount=0, Running=0, Done=0. Reset mid-run aborts immediately; no partial update survives.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on Start: PC←START_ADDR[ProgSel], CycleCount←0.
  - RUN→DONE on Halt: PC holds the halt instruction address.
  - DONE→RUN on Start: same load as from IDLE.
  - Otherwise the state holds.
- Start is ignored in RUN.
- Running and Done are registered decodes of the state (one-hot; never both high).
- InstAddress = PC, registered. The ROM read is combinational, so an instruction is available the same cycle and there is one cycle per instruction.
- In RUN, priority per cycle: Halt > Stall > BranchAbs > BranchRel > increment.
  - Halt: go to DONE, PC unchanged.
  - Stall: PC unchanged.
  - BranchAbs: PC←lut[TargetIdx].
  - BranchRel: PC←PC + sign-extend(Offset), modulo 2^AW.
  - Else: PC←PC+1, modulo 2^AW (1023 wraps to 0).
- Both branch inputs high in one cycle: BranchAbs wins; no error is raised.
- Branch, Stall and Halt inputs are ignored outside RUN.
- CycleCount:
  - Increments every RUN cycle, including stalled cycles and the Halt cycle.
  - Saturates at 2^CW-1.
  - Holds in DONE and IDLE; cleared on each Start load.
- Relative arithmetic is done in AW bits: Offset -32..+31, and the result wraps.

Decomposition:
- Package fetch_pkg holds:
  - AW, LUT_IW, OFF_W, CW;
  - fetch_state_t enum {IDLE, RUN, DONE};
  - START_ADDR[4] constants (0, 256, 512, 768);
  - the BRANCH_TARGETS[32] constant array, written by the assembler flow.
- One sub-module, branch_lut: combinational index-to-target lookup of BRANCH_TARGETS. It is kept separate so the assembler flow can regenerate it independently.

Test Plan:
- Reset mid-run: assert Reset at PC=37 in RUN → InstAddress=0, Running=0, Done=0, CycleCount=0 immediately, with no clock edge needed.
- Start with ProgSel=1, no branches, 5 cycles → InstAddress 256,257,258,259,260; Halt at 260 → Done=1, InstAddress stays 260, CycleCount=5.
- At PC=300: BranchRel with Offset=-4 → 296. Then Offset=+31 → 327. Then PC=1020 with Offset=+5 → wraps to 1.
- BranchAbs TargetIdx=3 (LUT=600) together with BranchRel, Offset=+2 → PC=600. Stall together with BranchAbs → PC holds. Halt together with Stall → DONE.
- Increment from 1023 → 0. Start pulsed during RUN → ignored, PC continues. Start in DONE with ProgSel=2 → PC=512, CycleCount restarts at 0.
- Force a long run with CW=4 override: 20 RUN cycles → CycleCount saturates at 15.
